conv_slice_scheduler: RTL



---
 rtl/conv_slice_scheduler_pkg.sv | 26 ++
 rtl/conv_feed_addr_gen.sv | 103 ++++++++++
 rtl/conv_slice_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/conv_slice_scheduler_pkg.sv
// Shared constants and state encoding for the conv slice scheduler and the layer module.
package conv_slice_scheduler_pkg;

    localparam int PARA_X                 = 3;
    localparam int PARA_KERNEL            = 2;
    localparam int KERNEL_SIZE_WIDTH      = 6;
    localparam int KERNEL_SIZE_MAX        = 5;
    localparam int READ_ADDR_WIDTH        = 3;
    localparam int WEIGHT_READ_ADDR_WIDTH = 10;
    localparam int CLK_NUM_WIDTH          = 8;
    localparam int LANE_WIDTH             = 2;
    localparam int KSQ_WIDTH              = 2 * KERNEL_SIZE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FEED,
        S_WAIT,
        S_WB
    } state_t;

    function automatic logic kernel_size_legal(input logic [KERNEL_SIZE_WIDTH-1:0] ks);
        return (ks != '0) && (ks <= KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX));
    endfunction

endpackage

// File: rtl/conv_feed_addr_gen.sv
// Walks one ks x ks window: per-lane row pointers, column index and weight address.
// Addresses are registered so each presented value is stable for the whole RAM read cycle.
module conv_feed_addr_gen
    import conv_slice_scheduler_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  init,
    input  logic                                  advance,
    input  logic [KERNEL_SIZE_WIDTH-1:0]          kernel_size,
    input  logic [READ_ADDR_WIDTH-1:0]            fm_base,
    input  logic [READ_ADDR_WIDTH-1:0]            fm_row_step,
    input  logic [WEIGHT_READ_ADDR_WIDTH-1:0]     weight_base,
    output logic [PARA_X*READ_ADDR_WIDTH-1:0]     fm_addr_read,
    output logic [PARA_X*READ_ADDR_WIDTH-1:0]     fm_sub_addr_read,
    output logic [WEIGHT_READ_ADDR_WIDTH-1:0]     weight_addr_read,
    output logic                                  last,
    output logic                                  first_col,
    output logic [LANE_WIDTH-1:0]                 lane
);

    logic [KERNEL_SIZE_WIDTH-1:0]      ks_q;
    logic [KSQ_WIDTH-1:0]              ks_sq_q;
    logic [READ_ADDR_WIDTH-1:0]        step_q;
    logic [WEIGHT_READ_ADDR_WIDTH-1:0] wbase_q;
    logic [KSQ_WIDTH-1:0]              k_cnt;
    logic [KERNEL_SIZE_WIDTH-1:0]      c_cnt;
    logic [LANE_WIDTH-1:0]             lane_cnt;
    logic [READ_ADDR_WIDTH-1:0]        row_ptr  [PARA_X];
    logic [READ_ADDR_WIDTH-1:0]        fm_addr_q[PARA_X];
    logic [READ_ADDR_WIDTH-1:0]        fm_sub_q [PARA_X];
    logic [WEIGHT_READ_ADDR_WIDTH-1:0] weight_q;
    logic                              last_q;
    logic                              first_col_q;
    logic [LANE_WIDTH-1:0]             lane_q;

    // Counters hold the next k to present; each advance publishes it and steps c/lane
    // without a divider. Row pointer bumps in the same edge its lane's row ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_q        <= '0;
            ks_sq_q     <= '0;
            step_q      <= '0;
            wbase_q     <= '0;
            k_cnt       <= '0;
            c_cnt       <= '0;
            lane_cnt    <= '0;
            weight_q    <= '0;
            last_q      <= 1'b0;
            first_col_q <= 1'b0;
            lane_q      <= '0;
            for (int i = 0; i < PARA_X; i++) begin
                row_ptr[i]   <= '0;
                fm_addr_q[i] <= '0;
                fm_sub_q[i]  <= '0;
            end
        end else if (init) begin
            ks_q        <= kernel_size;
            ks_sq_q     <= KSQ_WIDTH'(kernel_size) * KSQ_WIDTH'(kernel_size);
            step_q      <= fm_row_step;
            wbase_q     <= weight_base;
            k_cnt       <= '0;
            c_cnt       <= '0;
            lane_cnt    <= '0;
            weight_q    <= weight_base;
            last_q      <= 1'b0;
            first_col_q <= 1'b0;
            lane_q      <= '0;
            for (int i = 0; i < PARA_X; i++) begin
                row_ptr[i]   <= fm_base;
                fm_addr_q[i] <= fm_base;
                fm_sub_q[i]  <= '0;
            end
        end else if (advance) begin
            fm_addr_q[lane_cnt] <= row_ptr[lane_cnt];
            fm_sub_q[lane_cnt]  <= READ_ADDR_WIDTH'(c_cnt);
            weight_q            <= wbase_q + WEIGHT_READ_ADDR_WIDTH'(k_cnt);
            lane_q              <= lane_cnt;
            first_col_q         <= (c_cnt == '0);
            last_q              <= (k_cnt == ks_sq_q - KSQ_WIDTH'(1));
            k_cnt               <= k_cnt + KSQ_WIDTH'(1);
            if (c_cnt == ks_q - KERNEL_SIZE_WIDTH'(1)) begin
                c_cnt             <= '0;
                row_ptr[lane_cnt] <= row_ptr[lane_cnt] + step_q;
                lane_cnt          <= (lane_cnt == LANE_WIDTH'(PARA_X - 1)) ? '0
                                                                          : lane_cnt + LANE_WIDTH'(1);
            end else begin
                c_cnt <= c_cnt + KERNEL_SIZE_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < PARA_X; g++) begin : g_lane_out
        assign fm_addr_read[g*READ_ADDR_WIDTH +: READ_ADDR_WIDTH]     = fm_addr_q[g];
        assign fm_sub_addr_read[g*READ_ADDR_WIDTH +: READ_ADDR_WIDTH] = fm_sub_q[g];
    end

    assign weight_addr_read = weight_q;
    assign last             = last_q;
    assign first_col        = first_col_q;
    assign lane             = lane_q;

endmodule

// File: rtl/conv_slice_scheduler.sv
// Sequences one convolution window: address issue, data steering, result wait and writeback.
module conv_slice_scheduler
    import conv_slice_scheduler_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]          kernel_size,
    input  logic [READ_ADDR_WIDTH-1:0]            fm_base,
    input  logic [READ_ADDR_WIDTH-1:0]            fm_row_step,
    input  logic [WEIGHT_READ_ADDR_WIDTH-1:0]     weight_base,
    output logic                                  fm_ena_wr,
    output logic [PARA_X*READ_ADDR_WIDTH-1:0]     fm_addr_read,
    output logic [PARA_X*READ_ADDR_WIDTH-1:0]     fm_sub_addr_read,
    output logic [WEIGHT_READ_ADDR_WIDTH-1:0]     weight_addr_read,
    output logic                                  conv_rst,
    output logic                                  feed_valid,
    output logic                                  load_full,
    output logic [LANE_WIDTH-1:0]                 lane_sel,
    input  logic [PARA_KERNEL-1:0]                conv_out_ready,
    output logic                                  wb_req,
    input  logic                                  wb_ack,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);

    localparam logic [CLK_NUM_WIDTH-1:0] WAIT_LAST = CLK_NUM_WIDTH'((1 << CLK_NUM_WIDTH) - 2);

    state_t                   state;
    state_t                   next_state;
    logic [CLK_NUM_WIDTH-1:0] wait_cnt;
    logic                     accept;
    logic                     reject;
    logic                     timeout;
    logic                     ack_accept;
    logic                     advance;
    logic                     last;
    logic                     first_col;
    logic [LANE_WIDTH-1:0]    cur_lane;

    conv_feed_addr_gen u_addr_gen (
        .clk              (clk),
        .rst              (rst),
        .init             (accept),
        .advance          (advance),
        .kernel_size      (kernel_size),
        .fm_base          (fm_base),
        .fm_row_step      (fm_row_step),
        .weight_base      (weight_base),
        .fm_addr_read     (fm_addr_read),
        .fm_sub_addr_read (fm_sub_addr_read),
        .weight_addr_read (weight_addr_read),
        .last             (last),
        .first_col        (first_col),
        .lane             (cur_lane)
    );

    // Result-ready has priority over the timeout in the same WAIT cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        timeout    = 1'b0;
        ack_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (kernel_size_legal(kernel_size)) begin
                        accept     = 1'b1;
                        next_state = S_PRIME;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_PRIME: next_state = S_FEED;
            S_FEED: begin
                if (last) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (&conv_out_ready) begin
                    next_state = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_WB: begin
                if (wb_ack) begin
                    ack_accept = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign advance   = (state == S_PRIME) || ((state == S_FEED) && !last);
    assign fm_ena_wr = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wb_req    = (state == S_WB);
    assign conv_rst  = (state == S_FEED) || (state == S_WAIT) || (state == S_WB);

    // Steering trails the address by one cycle to match the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            feed_valid <= 1'b0;
            load_full  <= 1'b0;
            lane_sel   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= next_state;
            wait_cnt   <= (state == S_WAIT) ? wait_cnt + CLK_NUM_WIDTH'(1) : '0;
            feed_valid <= (state == S_FEED);
            load_full  <= (state == S_FEED) && first_col;
            lane_sel   <= (state == S_FEED) ? cur_lane : '0;
            done       <= ack_accept;
            error      <= reject || timeout;
        end
    end

endmodule
